// File: rtl/ternary_mvm_stream.sv
// ---------------------------------------------------------------------------
// ternary_mvm_stream
//
// Streaming ternary matrix-vector multiplier. Every accepted input beat
// carries LANES signed activations plus a 2-bit ternary weight for every
// (output, lane) pair. The beat's per-output sums are accumulated into
// OUT_LEN accumulators until a beat marked last arrives. The OUT_LEN results
// are then drained one per output handshake, index 0 first.
//
// Weight codes: 00 -> 0, 01 -> +x, 10 -> -x, 11 -> -x.
//
// Parameters
//   LANES    activations per input beat
//   OUT_LEN  number of outputs / accumulators
//   BW       activation width (two's complement)
//   ACC_W    accumulator / result width, must exceed BW
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat (registered)
//   in_last    beat closes the current vector
//   vec_in     lane l = vec_in[l*BW +: BW]
//   w_in       weight(o,l) = w_in[2*(o*LANES+l) +: 2]
//   out_valid  out_data holds a result (registered)
//   out_ready  downstream accepts the current result
//   out_data   signed result for out_idx (muxed from registered accumulators)
//   out_idx    index of the current result
//   out_last   high with out_valid on index OUT_LEN-1 (registered)
//   sat_flag   present only with TERNARY_MVM_SAT_EN; sticky clamp indicator
//              for the current vector, meaningful during the drain phase
//
// Build option
//   TERNARY_MVM_SAT_EN  defined: every accumulate clamps to the signed
//                       ACC_W range and sat_flag is added.
//                       undefined: accumulators wrap modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module ternary_mvm_stream #(
    parameter int LANES   = 2,
    parameter int OUT_LEN = 7,
    parameter int BW      = 8,
    parameter int ACC_W   = 16,
    localparam int IDX_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [LANES*BW-1:0]          vec_in,
    input  logic [2*LANES*OUT_LEN-1:0]   w_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last
`ifdef TERNARY_MVM_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    // Beat sums carry enough headroom for LANES full-scale terms of either
    // sign; the accumulate adds one more bit so the true (unwrapped) result
    // is always available for clamping.
    localparam int SUM_W = ACC_W + $clog2(LANES) + 1;
    localparam int TOT_W = SUM_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(OUT_LEN - 1);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(OUT_LEN - 2);

    generate
        if (ACC_W <= BW) begin : g_bad_acc_w
            $error("ternary_mvm_stream: ACC_W must be greater than BW");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    logic [ACC_W-1:0]        acc      [OUT_LEN];
    logic [ACC_W-1:0]        acc_next [OUT_LEN];
    logic signed [SUM_W-1:0] beat_sum [OUT_LEN];
    logic signed [TOT_W-1:0] total    [OUT_LEN];
    logic                    clamp_any;
    logic                    beat_fire;

    assign beat_fire = in_valid && in_ready;

    // The accumulators are stable for the whole drain, so selecting by the
    // registered index gives a glitch-free, register-driven result.
    assign out_data = acc[out_idx];

`ifdef TERNARY_MVM_SAT_EN
    localparam logic signed [TOT_W-1:0] SAT_MAX =
        {{(TOT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [TOT_W-1:0] SAT_MIN =
        {{(TOT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`endif

    // -----------------------------------------------------------------------
    // Datapath: per-output beat sum and next accumulator value.
    // -----------------------------------------------------------------------
    always_comb begin
        logic signed [SUM_W-1:0] lane_ext;
        logic signed [TOT_W-1:0] acc_base;
        logic [1:0]              code;
        // NOTE: every variable assigned in this block gets a default on
        // entry, so no path through the loops can leave one holding its old
        // value and turn it into a latch.
        lane_ext  = '0;
        acc_base  = '0;
        code      = 2'b00;
        clamp_any = 1'b0;
        for (int o = 0; o < OUT_LEN; o++) begin
            beat_sum[o] = '0;
            acc_next[o] = '0;
            total[o]    = '0;
        end

        for (int o = 0; o < OUT_LEN; o++) begin
            for (int l = 0; l < LANES; l++) begin
                // Sign-extend before negating so -(-2^(BW-1)) stays exact.
                lane_ext = {{(SUM_W-BW){vec_in[l*BW+BW-1]}}, vec_in[l*BW +: BW]};
                code     = w_in[2*(o*LANES+l) +: 2];
                if (code[1]) begin
                    beat_sum[o] = beat_sum[o] - lane_ext;
                end else if (code[0]) begin
                    beat_sum[o] = beat_sum[o] + lane_ext;
                end
            end

            // The first beat of a vector replaces whatever the accumulators
            // held from the previous vector.
            acc_base = (state == IDLE) ? '0
                                       : {{(TOT_W-ACC_W){acc[o][ACC_W-1]}}, acc[o]};
            total[o] = acc_base + {beat_sum[o][SUM_W-1], beat_sum[o]};

`ifdef TERNARY_MVM_SAT_EN
            if (total[o] > SAT_MAX) begin
                acc_next[o] = SAT_MAX[ACC_W-1:0];
                clamp_any   = 1'b1;
            end else if (total[o] < SAT_MIN) begin
                acc_next[o] = SAT_MIN[ACC_W-1:0];
                clamp_any   = 1'b1;
            end else begin
                acc_next[o] = total[o][ACC_W-1:0];
            end
`else
            acc_next[o] = total[o][ACC_W-1:0];
`endif
        end
    end

`ifndef TERNARY_MVM_SAT_EN
    // Without clamping only the low ACC_W bits of each total are kept; the
    // upper bits and the clamp indicator are deliberately discarded.
    logic unused_hi;
    always_comb begin
        unused_hi = clamp_any;
        for (int o = 0; o < OUT_LEN; o++) begin
            unused_hi = unused_hi ^ (^total[o][TOT_W-1:ACC_W]);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // -----------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of the
    // order of statements or of other always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            // NOTE: the accumulator array is reset explicitly because it
            // feeds out_data directly, which must read zero out of reset;
            // this is the one storage array in the block that needs it.
            for (int o = 0; o < OUT_LEN; o++) begin
                acc[o] <= '0;
            end
`ifdef TERNARY_MVM_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (beat_fire) begin
                        acc <= acc_next;
`ifdef TERNARY_MVM_SAT_EN
                        // First beat of a vector starts a fresh sticky flag.
                        sat_flag <= ((state == IDLE) ? 1'b0 : sat_flag) | clamp_any;
`endif
                        if (in_last) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_idx   <= '0;
                            out_last  <= (OUT_LEN == 1);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (out_idx == LAST_IDX) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                        end else begin
                            out_idx  <= out_idx + IDX_W'(1);
                            out_last <= (out_idx == PRE_LAST_IDX);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// ---------------------------------------------------------------------------
// tb_ternary_mvm_stream
//
// Directed, self-checking bench for ternary_mvm_stream at default parameters
// (LANES=2, OUT_LEN=7, BW=8, ACC_W=16). Expected results are hand-computed
// constants. Inputs change 1 ns after the rising edge; outputs are sampled
// at the same point, well away from the edge.
// ---------------------------------------------------------------------------
module tb_ternary_mvm_stream;

    localparam int LANES   = 2;
    localparam int OUT_LEN = 7;
    localparam int BW      = 8;
    localparam int ACC_W   = 16;
    localparam int IDX_W   = 3;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic [LANES*BW-1:0]        vec_in;
    logic [2*LANES*OUT_LEN-1:0] w_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_data;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_last;
`ifdef TERNARY_MVM_SAT_EN
    logic                       sat_flag;
`endif

    ternary_mvm_stream #(
        .LANES  (LANES),
        .OUT_LEN(OUT_LEN),
        .BW     (BW),
        .ACC_W  (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .vec_in   (vec_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last)
`ifdef TERNARY_MVM_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef logic [OUT_LEN-1:0][ACC_W-1:0] exp_t;

    typedef struct packed {
        logic signed [BW-1:0]       a0;
        logic signed [BW-1:0]       a1;
        logic [2*LANES*OUT_LEN-1:0] w;
        logic [15:0]                nbeats;
        exp_t                       exp;
    } vec_t;

    localparam int NVEC = 4;
    vec_t tbl [NVEC];

    int checks = 0;
    int errors = 0;

    logic stall_pat [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int e0, input int e1, input int e2, input int e3,
                                    input int e4, input int e5, input int e6);
        return {16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        vec_in    = '0;
        w_in      = '0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_data", out_data, 0);
`ifdef TERNARY_MVM_SAT_EN
        check("reset_sat_flag", sat_flag, 0);
`endif
        rst = 1'b0;
        tick();
        check("release_in_ready", in_ready, 1);
    endtask

    // Presents one beat and holds it until accepted (bounded wait).
    task automatic send_beat(input logic signed [BW-1:0] a0, input logic signed [BW-1:0] a1,
                             input logic [2*LANES*OUT_LEN-1:0] w, input logic last);
        int n;
        n        = 0;
        vec_in   = {a1, a0};
        w_in     = w;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("beat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) begin
            // Result must be presented the cycle after the last beat.
            check("latency_out_valid", out_valid, 1);
            check("latency_in_ready_low", in_ready, 0);
        end
    endtask

    task automatic send_vec(input logic signed [BW-1:0] a0, input logic signed [BW-1:0] a1,
                            input logic [2*LANES*OUT_LEN-1:0] w, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(a0, a1, w, (b == nbeats - 1));
        end
    endtask

    // Drains all results with out_ready held high.
    task automatic drain_all(input string tag, input exp_t exp);
        for (int i = 0; i < OUT_LEN; i++) begin
            check($sformatf("%s_valid[%0d]", tag, i), out_valid, 1);
            check($sformatf("%s_in_ready[%0d]", tag, i), in_ready, 0);
            check($sformatf("%s_idx[%0d]", tag, i), out_idx, i);
            check($sformatf("%s_data[%0d]", tag, i), out_data, exp[i]);
            check($sformatf("%s_last[%0d]", tag, i), out_last, (i == OUT_LEN - 1));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check($sformatf("%s_done_valid", tag), out_valid, 0);
        check($sformatf("%s_done_in_ready", tag), in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t exp6;
        int   exp_idx;
        int   cyc;

        // ----- vector table -----
        // w literal per output (o6 .. o0), each nibble is {lane1 code, lane0 code}.
        tbl[0].a0 = 3;    tbl[0].a1 = -5;  tbl[0].nbeats = 1;
        tbl[0].w  = 28'b0101_0101_0101_0101_1001_0101_0101;
        tbl[0].exp = mk_exp(-2, -2, 8, -2, -2, -2, -2);

        tbl[1].a0 = 1;    tbl[1].a1 = 1;   tbl[1].nbeats = 8;
        tbl[1].w  = 28'b0001_0001_0001_0001_0001_0001_0001;
        tbl[1].exp = mk_exp(8, 8, 8, 8, 8, 8, 8);

        // lane0 code 10 on even outputs, 11 on odd outputs: both negate.
        tbl[2].a0 = -128; tbl[2].a1 = 0;   tbl[2].nbeats = 1;
        tbl[2].w  = 28'b0010_0011_0010_0011_0010_0011_0010;
        tbl[2].exp = mk_exp(128, 128, 128, 128, 128, 128, 128);

        // Mixed codes, two beats of (7,-3).
        tbl[3].a0 = 7;    tbl[3].a1 = -3;  tbl[3].nbeats = 2;
        tbl[3].w  = 28'b0110_0000_1001_0011_1100_0101_1111;
        tbl[3].exp = mk_exp(-8, 8, 6, -14, 20, 0, -20);

        stall_pat[0] = 1'b1;
        stall_pat[1] = 1'b0;
        stall_pat[2] = 1'b0;
        stall_pat[3] = 1'b1;

        do_reset();

        // ----- table-driven vectors -----
        for (int k = 0; k < NVEC; k++) begin
            send_vec(tbl[k].a0, tbl[k].a1, tbl[k].w, int'(tbl[k].nbeats));
            drain_all($sformatf("vec%0d", k), tbl[k].exp);
        end

        // ----- out_ready stalls: 1,0,0,1 repeating -----
        send_vec(tbl[0].a0, tbl[0].a1, tbl[0].w, 1);
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < OUT_LEN && cyc < 60) begin
            out_ready = stall_pat[cyc % 4];
            check($sformatf("stall_valid[c%0d]", cyc), out_valid, 1);
            check($sformatf("stall_idx[c%0d]", cyc), out_idx, exp_idx);
            check($sformatf("stall_data[c%0d]", cyc), out_data, tbl[0].exp[exp_idx]);
            check($sformatf("stall_last[c%0d]", cyc), out_last, (exp_idx == OUT_LEN - 1));
            tick();
            if (out_ready) exp_idx++;
            cyc++;
        end
        out_ready = 1'b0;
        check("stall_all_drained", exp_idx, OUT_LEN);
        check("stall_done_valid", out_valid, 0);

        // ----- reset during beat 3 of 5 -----
        send_beat(10, 10, 28'h5555555, 1'b0);
        send_beat(10, 10, 28'h5555555, 1'b0);
        vec_in   = {8'sd10, 8'sd10};
        w_in     = 28'h5555555;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_accum_out_valid", out_valid, 0);
        check("rst_accum_in_ready", in_ready, 0);
        tick();
        check("rst_accum_release_ready", in_ready, 1);
        send_vec(tbl[3].a0, tbl[3].a1, tbl[3].w, 2);
        drain_all("after_rst_accum", tbl[3].exp);

        // ----- reset mid-drain -----
        send_vec(tbl[0].a0, tbl[0].a1, tbl[0].w, 1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        check("mid_drain_idx", out_idx, 3);
        rst = 1'b1;
        tick();
        check("rst_drain_out_valid", out_valid, 0);
        check("rst_drain_out_last", out_last, 0);
        check("rst_drain_out_idx", out_idx, 0);
        check("rst_drain_out_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("rst_drain_release_ready", in_ready, 1);
        send_vec(tbl[2].a0, tbl[2].a1, tbl[2].w, 1);
        drain_all("after_rst_drain", tbl[2].exp);

        // ----- 300 beats of (127,127), all +1: 76200 true sum -----
        send_vec(127, 127, 28'h5555555, 300);
`ifdef TERNARY_MVM_SAT_EN
        exp6 = mk_exp(32767, 32767, 32767, 32767, 32767, 32767, 32767);
        check("sat_flag_set", sat_flag, 1);
`else
        exp6 = mk_exp(10664, 10664, 10664, 10664, 10664, 10664, 10664);
`endif
        drain_all("long", exp6);

        // Next vector: sat_flag cleared by its first beat, results fresh.
        send_vec(tbl[0].a0, tbl[0].a1, tbl[0].w, 1);
`ifdef TERNARY_MVM_SAT_EN
        check("sat_flag_cleared", sat_flag, 0);
`endif
        drain_all("post_long", tbl[0].exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
